// File: rtl/ppb_serial_link.sv
`default_nettype none
// ============================================================================
// Module : ppb_serial_link
// Panel-side SPI mode-0 target: frames device_inputs in, device_outputs out.
// Option : define PPB_LINK_PARITY_EN to append an even-parity bit per direction.
// Rev    : 1.0
// ============================================================================
module ppb_serial_link #(
  parameter int IN_BITS     = 60,
  parameter int OUT_BITS    = 120,
  parameter int FRAME_BITS  = 120,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic [0:OUT_BITS-1] device_outputs,
  output logic [0:IN_BITS-1]  device_inputs,
  output logic                frame_valid,
  output logic                frame_error,
  output logic                busy
);

`ifdef PPB_LINK_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int               FRAME_LEN = FRAME_BITS + (PARITY_EN ? 1 : 0);
  localparam int               CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_LEN   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One extra stage on sclk/cs_n holds the previous synchronised level for edge detection.
  logic [SYNC_STAGES:0]   sclk_pipe;
  logic [SYNC_STAGES:0]   cs_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;

  logic sclk_s, sclk_prev, cs_s, cs_prev, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [0:IN_BITS-1]   in_sr;
  logic [0:OUT_BITS-1]  out_sr;
  logic                 tx_par;
  logic                 rx_par;
  logic                 restart;
  logic                 tx_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign sclk_prev = sclk_pipe[SYNC_STAGES];
  assign cs_s      = cs_pipe[SYNC_STAGES-1];
  assign cs_prev   = cs_pipe[SYNC_STAGES];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Bit presented after the sclk fall that follows receive bit (cnt-1).
  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < OUT_BITS; i++) begin
      if (cnt == CNT_W'(i)) tx_bit = out_sr[i];
    end
    if (PARITY_EN && cnt == CNT_W'(FRAME_BITS)) tx_bit = tx_par;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      in_sr         <= '0;
      out_sr        <= '0;
      tx_par        <= 1'b0;
      rx_par        <= 1'b0;
      restart       <= 1'b0;
      device_inputs <= '0;
      miso          <= 1'b0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          miso    <= 1'b0;
          restart <= 1'b0;
          // A fall seen while in DONE has no edge left to detect here; restart covers it.
          if (cs_fall || (restart && !cs_s)) begin
            state  <= S_SHIFT;
            out_sr <= device_outputs;
            tx_par <= ^device_outputs;
            miso   <= device_outputs[0];
            cnt    <= '0;
            in_sr  <= '0;
            rx_par <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            state <= S_DONE;
          end else if (sclk_rise) begin
            for (int i = 0; i < IN_BITS; i++) begin
              if (cnt == CNT_W'(i)) in_sr[i] <= mosi_s;
            end
            if (cnt < CNT_LEN) rx_par <= rx_par ^ mosi_s;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end else if (sclk_fall) begin
            miso <= tx_bit;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          miso    <= 1'b0;
          restart <= ~cs_s;
          if (cnt == CNT_LEN && (!PARITY_EN || !rx_par)) begin
            device_inputs <= in_sr;
            frame_valid   <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppb_serial_link.sv
`default_nettype none
// Testbench for ppb_serial_link: directed and random SPI frames checked
// against a frame-level model through pulse and MISO scoreboards.
module tb_ppb_serial_link;

  localparam int IN_BITS     = 60;
  localparam int OUT_BITS    = 120;
  localparam int FRAME_BITS  = 120;
  localparam int SYNC_STAGES = 2;
`ifdef PPB_LINK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LEN  = FRAME_BITS + (PAR ? 1 : 0);
  localparam int HALF = 4;

  logic                clk   = 1'b0;
  logic                reset = 1'b0;
  logic                sclk  = 1'b0;
  logic                cs_n  = 1'b1;
  logic                mosi  = 1'b0;
  logic                miso;
  logic [0:OUT_BITS-1] device_outputs = '0;
  logic [0:IN_BITS-1]  device_inputs;
  logic                frame_valid;
  logic                frame_error;
  logic                busy;

  ppb_serial_link #(
    .IN_BITS    (IN_BITS),
    .OUT_BITS   (OUT_BITS),
    .FRAME_BITS (FRAME_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso),
    .device_outputs(device_outputs),
    .device_inputs (device_inputs),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 is_valid;
    logic [0:IN_BITS-1] di;
  } pulse_t;

  typedef struct {
    int           n;
    logic [0:127] bits;
  } miso_t;

  pulse_t             pulse_q[$];
  miso_t              miso_q[$];
  int                 checks = 0;
  int                 passes = 0;
  logic [0:IN_BITS-1] model_di = '0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [0:OUT_BITS-1] rand_dout();
    logic [0:OUT_BITS-1] v;
    for (int k = 0; k < OUT_BITS; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [0:127] rand_bits();
    logic [0:127] v;
    for (int k = 0; k < 128; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Put the correct even-parity bit after the data bits (no-op without parity).
  function automatic logic [0:127] with_parity(input logic [0:127] b);
    logic [0:127] v;
    logic         p;
    v = b;
    p = 1'b0;
    for (int k = 0; k < FRAME_BITS; k++) p ^= v[k];
    if (PAR) v[FRAME_BITS] = p;
    return v;
  endfunction

  // Pulse scoreboard: every frame_valid/frame_error must match the oldest expectation.
  always @(negedge clk) begin : pulse_mon
    pulse_t e;
    if (frame_valid === 1'b1 || frame_error === 1'b1) begin
      if (pulse_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: valid=%b error=%b expected no pulse", frame_valid, frame_error);
      end else begin
        e = pulse_q.pop_front();
        check("pulse_kind", 128'({frame_valid, frame_error}), 128'({e.is_valid, ~e.is_valid}));
        check("device_inputs", 128'(device_inputs), 128'(e.di));
      end
    end
  end

  // MISO scoreboard: capture like the controller (on sclk rise) and compare per frame.
  initial begin : miso_mon
    miso_t        e;
    logic [0:127] cap;
    int           cap_n;
    forever begin
      @(negedge cs_n);
      cap   = '0;
      cap_n = 0;
      forever begin
        @(posedge sclk or posedge cs_n);
        if (cs_n) break;
        if (cap_n < 128) cap[cap_n] = miso;
        cap_n++;
      end
      if (miso_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_frame: captured %0d miso bits, expected no frame", cap_n);
      end else begin
        e = miso_q.pop_front();
        check("miso_len", 128'(cap_n), 128'(e.n));
        check("miso_bits", 128'(cap), 128'(e.bits));
      end
    end
  end

  task automatic send_frame(input int n, input logic [0:127] bits, input int abort_at, input bit glitch_end);
    miso_t               m;
    pulse_t              p;
    logic [0:OUT_BITS-1] snap;
    logic                par;
    bit                  ok;
    snap   = device_outputs;
    m.n    = (abort_at >= 0) ? abort_at : n;
    m.bits = '0;
    for (int k = 0; k < m.n && k < 128; k++) begin
      if (k < OUT_BITS) m.bits[k] = snap[k];
      else if (PAR && k == FRAME_BITS) m.bits[k] = ^snap;
      else m.bits[k] = 1'b0;
    end
    miso_q.push_back(m);
    par = 1'b0;
    for (int k = 0; k < LEN; k++) par ^= bits[k];
    ok = (n == LEN) && (!PAR || par == 1'b0);
    if (abort_at < 0) begin
      if (ok) model_di = bits[0:IN_BITS-1];
      p.is_valid = ok;
      p.di       = model_di;
      pulse_q.push_back(p);
    end

    if (cs_n) begin
      @(negedge clk);
      cs_n = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    check("busy_open", 128'(busy), 128'(1'b1));
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        reset = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_outputs", 128'({device_inputs, miso, frame_valid, frame_error, busy}), 128'(0));
        reset    = 1'b1;
        model_di = '0;
        repeat (HALF) @(negedge clk);
        return;
      end
      mosi = bits[k];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (k == n / 2) device_outputs = rand_dout();
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (glitch_end) cs_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("latency_early", 128'(frame_valid | frame_error), 128'(1'b0));
    @(negedge clk);
    check("latency_pulse", 128'(frame_valid | frame_error), 128'(1'b1));
    if (!glitch_end) begin
      repeat (HALF) @(negedge clk);
      check("busy_idle", 128'(busy), 128'(1'b0));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [0:127] bits;
    int           n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_di", 128'(device_inputs), 128'(0));
    check("reset_miso", 128'(miso), 128'(0));
    check("reset_valid", 128'(frame_valid), 128'(0));
    check("reset_error", 128'(frame_error), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // sclk activity with the frame deselected must produce nothing
    repeat (10) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_di", 128'(device_inputs), 128'(0));

    bits       = '0;
    bits[0:10] = 11'b101_1010_0101;
    send_frame(LEN, with_parity(bits), -1, 1'b0);
    check("directed_di", 128'(device_inputs[0:10]), 128'(11'b101_1010_0101));

    device_outputs       = '0;
    device_outputs[0:7]  = 8'h3C;
    device_outputs[56]   = 1'b1;
    send_frame(LEN, with_parity(rand_bits()), -1, 1'b0);

    send_frame(LEN - 1, rand_bits(), -1, 1'b0);
    send_frame(LEN + 1, rand_bits(), -1, 1'b0);
    send_frame(0, rand_bits(), -1, 1'b0);

    send_frame(LEN, with_parity(rand_bits()), 50, 1'b0);
    bits = '1;
    send_frame(LEN, with_parity(bits), -1, 1'b0);
    check("all_ones_di", 128'(device_inputs), 128'({IN_BITS{1'b1}}));

`ifdef PPB_LINK_PARITY_EN
    bits             = with_parity(rand_bits());
    bits[FRAME_BITS] = ~bits[FRAME_BITS];
    send_frame(LEN, bits, -1, 1'b0);
`endif

    // cs_n high for one clk only: back-to-back frames
    device_outputs = rand_dout();
    send_frame(LEN, with_parity(rand_bits()), -1, 1'b1);
    send_frame(LEN, with_parity(rand_bits()), -1, 1'b0);

    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 9))
        7:       n = LEN - 1;
        8:       n = LEN + 1;
        9:       n = $urandom_range(0, LEN);
        default: n = LEN;
      endcase
      bits = with_parity(rand_bits());
      if (PAR && $urandom_range(0, 3) == 0) bits[FRAME_BITS] = ~bits[FRAME_BITS];
      device_outputs = rand_dout();
      send_frame(n, bits, -1, 1'b0);
    end

    repeat (20) @(negedge clk);
    check("pulse_q_drained", 128'(pulse_q.size()), 128'(0));
    check("miso_q_drained", 128'(miso_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
